// File: rtl/answer_capture.sv
// answer_capture: player-input side of the mental-arithmetic game.
// The block synchronises the answer switches and the submit button, and debounces
// the button. On an arm pulse it opens a timed answer window. It latches the
// player's answer on a debounced submit press and compares it with the expected
// sum. Pass, fail or timeout is returned over a valid/ack handshake. Passed
// rounds are counted with saturation at 15.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-low reset
//   switch       raw answer switches (asynchronous)
//   submit       raw submit button, active-high (asynchronous, bouncy)
//   arm          one-cycle pulse that opens the answer window
//   expected     correct sum, sampled only when arm is accepted
//   result_ack   controller acknowledges the result
//   busy         high while the window is open or a result is pending
//   result_valid result fields valid, held until result_ack
//   pass         latched answer equals expected sum
//   timeout      window expired without a submit
//   answer       latched answer (0 after a timeout)
//   pass_count   saturating count of passed rounds
module answer_capture #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] switch,
  input  logic       submit,
  input  logic       arm,
  input  logic [7:0] expected,
  input  logic       result_ack,
  output logic       busy,
  output logic       result_valid,
  output logic       pass,
  output logic       timeout,
  output logic [7:0] answer,
  output logic [3:0] pass_count
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TmrW-1:0] TmrMax = TmrW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StArmed, StResult} state_e;

  state_e            state_q, state_d;
  logic [7:0]        sw_meta_q, sw_sync_q;
  logic              sub_meta_q, sub_sync_q;
  logic              db_level_q, db_level_d;
  logic              db_prev_q;
  logic [CntW-1:0]   db_cnt_q, db_cnt_d;
  logic [TmrW-1:0]   timer_q, timer_d;
  logic [7:0]        expected_q, expected_d;
  logic [7:0]        answer_q, answer_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic [3:0]        pass_count_q, pass_count_d;
  logic              submit_edge;
  logic              match;

  // Debounce: the level follows the synchronised button only after it has
  // differed for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    db_level_d = db_level_q;
    db_cnt_d   = db_cnt_q;
    if (sub_sync_q == db_level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == CntMax) begin
      db_level_d = sub_sync_q;
      db_cnt_d   = '0;
    end else begin
      db_cnt_d = db_cnt_q + CntW'(1);
    end
  end

  // A button already held when the window opens produces no edge here, so it
  // must be released and pressed again to count.
  assign submit_edge = db_level_q & ~db_prev_q;
  assign match       = (sw_sync_q == expected_q);

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    expected_d   = expected_q;
    answer_d     = answer_q;
    pass_d       = pass_q;
    timeout_d    = timeout_q;
    pass_count_d = pass_count_q;
    unique case (state_q)
      StIdle: begin
        if (arm) begin
          expected_d = expected;
          timer_d    = '0;
          state_d    = StArmed;
        end
      end
      StArmed: begin
        // Submit takes priority over a timer expiring in the same cycle.
        if (submit_edge) begin
          answer_d  = sw_sync_q;
          pass_d    = match;
          timeout_d = 1'b0;
          if (match && (pass_count_q != 4'd15)) begin
            pass_count_d = pass_count_q + 4'd1;
          end
          state_d = StResult;
        end else if (timer_q == TmrMax) begin
          answer_d  = '0;
          pass_d    = 1'b0;
          timeout_d = 1'b1;
          state_d   = StResult;
        end else begin
          timer_d = timer_q + TmrW'(1);
        end
      end
      StResult: begin
        // An arm arriving with the ack is dropped, not queued.
        if (result_ack) begin
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
      sub_meta_q   <= 1'b0;
      sub_sync_q   <= 1'b0;
      db_level_q   <= 1'b0;
      db_prev_q    <= 1'b0;
      db_cnt_q     <= '0;
      timer_q      <= '0;
      expected_q   <= '0;
      answer_q     <= '0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      pass_count_q <= '0;
    end else begin
      state_q      <= state_d;
      sw_meta_q    <= switch;
      sw_sync_q    <= sw_meta_q;
      sub_meta_q   <= submit;
      sub_sync_q   <= sub_meta_q;
      db_level_q   <= db_level_d;
      db_prev_q    <= db_level_q;
      db_cnt_q     <= db_cnt_d;
      timer_q      <= timer_d;
      expected_q   <= expected_d;
      answer_q     <= answer_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
      pass_count_q <= pass_count_d;
    end
  end

  assign busy         = (state_q != StIdle);
  assign result_valid = (state_q == StResult);
  assign pass         = pass_q;
  assign timeout      = timeout_q;
  assign answer       = answer_q;
  assign pass_count   = pass_count_q;

endmodule

// File: tb/tb_answer_capture.sv
`timescale 1ns/1ps
module tb_answer_capture;

  logic       clk;
  logic       rst;
  logic [7:0] switch;
  logic       submit;
  logic       arm;
  logic [7:0] expected;
  logic       result_ack;
  logic       busy;
  logic       result_valid;
  logic       pass;
  logic       timeout;
  logic [7:0] answer;
  logic [3:0] pass_count;

  typedef struct packed {
    logic [7:0] answer;
    logic       pass;
    logic       timeout;
    logic [3:0] pc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   model_pc = 0;
  logic rv_prev  = 1'b0;

  answer_capture #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .switch      (switch),
    .submit      (submit),
    .arm         (arm),
    .expected    (expected),
    .result_ack  (result_ack),
    .busy        (busy),
    .result_valid(result_valid),
    .pass        (pass),
    .timeout     (timeout),
    .answer      (answer),
    .pass_count  (pass_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: each rising result_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (result_valid && !rv_prev) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: answer %0d pass %0d timeout %0d, none expected",
                 answer, pass, timeout);
      end else begin
        mon_e = sb.pop_front();
        check("sb_answer", answer, mon_e.answer);
        check("sb_pass", pass, mon_e.pass);
        check("sb_timeout", timeout, mon_e.timeout);
        check("sb_pass_count", pass_count, mon_e.pc);
      end
    end
    rv_prev = result_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] a, input logic p, input logic t);
    exp_t e;
    if (p && model_pc < 15) model_pc++;
    e.answer  = a;
    e.pass    = p;
    e.timeout = t;
    e.pc      = model_pc[3:0];
    sb.push_back(e);
  endtask

  // Returns with time just after the edge that accepted arm.
  task automatic do_arm(input logic [7:0] v);
    arm      = 1'b1;
    expected = v;
    tick(1);
    arm      = 1'b0;
    expected = ~v;
  endtask

  task automatic wait_result(input int max, output int cycles);
    cycles = 0;
    while (!result_valid && cycles < max) begin
      tick(1);
      cycles++;
    end
  endtask

  task automatic do_ack(input string name);
    result_ack = 1'b1;
    tick(1);
    result_ack = 1'b0;
    check({name, "_ack_rv"}, result_valid, 0);
    check({name, "_ack_busy"}, busy, 0);
  endtask

  task automatic check_zero(input string name);
    check({name, "_busy"}, busy, 0);
    check({name, "_rv"}, result_valid, 0);
    check({name, "_pass"}, pass, 0);
    check({name, "_timeout"}, timeout, 0);
    check({name, "_answer"}, answer, 0);
    check({name, "_pass_count"}, pass_count, 0);
  endtask

  task automatic play_round(input string name, input logic [7:0] ev, input logic [7:0] sv);
    int c;
    switch = sv;
    tick(3);
    do_arm(ev);
    push_exp(sv, (sv == ev), 1'b0);
    submit = 1'b1;
    wait_result(20, c);
    check({name, "_latency"}, c, 7);
    do_ack(name);
    submit = 1'b0;
    tick(8);
  endtask

  initial begin
    int c;
    rst        = 1'b0;
    switch     = '0;
    submit     = 1'b0;
    arm        = 1'b0;
    expected   = '0;
    result_ack = 1'b0;
    tick(3);
    check_zero("reset");
    rst = 1'b1;
    tick(2);

    // Clean pass with latency check; answer holds after ack.
    play_round("t1", 8'd37, 8'd37);
    check("t1_answer_hold", answer, 37);
    check("t1_pass_cleared", pass, 0);

    // Wrong answer with a 1-0-1 bounce before settling.
    switch = 8'd36;
    tick(3);
    do_arm(8'd37);
    push_exp(8'd36, 1'b0, 1'b0);
    submit = 1'b1;
    tick(1);
    submit = 1'b0;
    tick(1);
    submit = 1'b1;
    wait_result(20, c);
    check("t2_latency", c, 7);
    do_ack("t2");
    submit = 1'b0;
    tick(10);
    check("t2_single_result", result_valid, 0);

    // Timeout, then arm pulses in RESULT are ignored.
    do_arm(8'd5);
    push_exp(8'd0, 1'b0, 1'b1);
    wait_result(15, c);
    check("t3_timeout_edges", c, 10);
    arm      = 1'b1;
    expected = 8'd99;
    tick(1);
    arm = 1'b0;
    check("t3_arm_ignored_rv", result_valid, 1);
    check("t3_arm_ignored_to", timeout, 1);
    arm        = 1'b1;
    result_ack = 1'b1;
    tick(1);
    arm        = 1'b0;
    result_ack = 1'b0;
    check("t3_arm_ack_busy", busy, 0);
    tick(2);
    check("t3_arm_dropped", busy, 0);

    // Button held across arm does not count; re-press inside next window does.
    switch = 8'd9;
    submit = 1'b1;
    tick(12);
    do_arm(8'd9);
    push_exp(8'd0, 1'b0, 1'b1);
    wait_result(15, c);
    check("t4_held_timeout", c, 10);
    do_ack("t4a");
    submit = 1'b0;
    tick(10);
    do_arm(8'd9);
    push_exp(8'd9, 1'b1, 1'b0);
    submit = 1'b1;
    wait_result(20, c);
    check("t4_repress_latency", c, 7);
    do_ack("t4b");
    submit = 1'b0;
    tick(8);

    // Submit edge on the same cycle the timer expires: submit wins.
    switch = 8'd200;
    tick(3);
    do_arm(8'd200);
    push_exp(8'd200, 1'b1, 1'b0);
    tick(3);
    submit = 1'b1;
    wait_result(20, c);
    check("t5_collide_latency", c, 7);
    do_ack("t5");
    submit = 1'b0;
    tick(8);

    // Saturation of pass_count.
    for (int i = 0; i < 16; i++) begin
      play_round("t5_sat", 8'(i * 3 + 1), 8'(i * 3 + 1));
    end
    check("t5_saturated", pass_count, 15);

    // Reset mid-ARMED.
    do_arm(8'd11);
    tick(3);
    rst = 1'b0;
    tick(1);
    check_zero("t6_armed");
    model_pc = 0;
    rst = 1'b1;
    tick(2);

    // Reset mid-RESULT.
    switch = 8'd50;
    tick(3);
    do_arm(8'd50);
    push_exp(8'd50, 1'b1, 1'b0);
    submit = 1'b1;
    wait_result(20, c);
    check("t6_result_latency", c, 7);
    rst = 1'b0;
    tick(1);
    submit = 1'b0;
    check_zero("t6_result");
    model_pc = 0;
    rst = 1'b1;
    tick(8);

    play_round("t6_after", 8'd77, 8'd77);
    check("t6_after_pc", pass_count, 1);
    check("t6_after_answer", answer, 77);

    tick(3);
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/answer_capture.md
Name: answer_capture

Overview:
- Player-input side of the mental-arithmetic game: the game controller presents a sequence of numbers and an expected sum, and this block collects the player's response.
- Debounces the submit button, synchronises the 8 slide switches, and latches the entered answer within a time-limited window.
- Compares the answer against the expected sum and returns pass/fail/timeout to the controller over a valid/ack handshake.
- Keeps a saturating count of passed rounds for display.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable clk cycles required before the debounced submit level changes (>=1).
- TIMEOUT_CYCLES, 10: clk cycles the answer window stays open after arm (>=2).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- switch  in  8  raw player answer switches (asynchronous)
- submit  in  1  raw submit push-button, active-high (asynchronous, bouncy)
- arm  in  1  single-cycle pulse from game controller: open answer window
- expected  in  8  correct sum; sampled only on the cycle arm is accepted
- result_ack  in  1  controller acknowledges result
- busy  out  1  high in ARMED and RESULT
- result_valid  out  1  result fields valid; held until acknowledged
- pass  out  1  answer == expected (valid with result_valid)
- timeout  out  1  window expired without a submit (valid with result_valid)
- answer  out  8  latched player answer; 0 on timeout
- pass_count  out  4  number of passed rounds, saturates at 15

Behaviour:
- Reset (rst==0 at a clk edge): state IDLE; all outputs 0; synchroniser flops, debounced level, debounce counter, timer and latched expected all cleared. Reset mid-window or mid-result aborts with no result.
- Synchronisers: switch and submit each pass through 2 flops; only the synchronised values are used.
- Debounce, running in every state:
  - Counter increments while the synchronised submit differs from the debounced level.
  - It clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the values still differ, the debounced level takes the new value and the counter clears.
- Submit edge: debounced level is 1 and its previous-cycle value is 0.
- IDLE:
  - busy=0.
  - On arm=1: latch expected, clear timer, go to ARMED.
  - Submit edges are ignored.
- ARMED:
  - busy=1; the timer increments each cycle.
  - On a submit edge: latch the synchronised switch value into answer, pass = (answer == expected), timeout=0, go to RESULT.
  - Otherwise, if timer == TIMEOUT_CYCLES-1: answer=0, pass=0, timeout=1, go to RESULT.
  - If both conditions occur in the same cycle, the submit wins.
  - A button already held when arm arrives does not count; it must be released and pressed again.
  - arm is ignored.
- RESULT:
  - result_valid=1; answer, pass and timeout are held stable.
  - pass_count increments once, on entry, when pass=1, saturating at 15.
  - On result_ack=1: clear result_valid, pass and timeout, go to IDLE. answer holds its value until the next latch.
  - arm while in RESULT is ignored. arm and result_ack in the same cycle: the ack is taken and the arm is dropped.
- Latency:
  - Raw submit rising and stable at cycle t gives result_valid=1 at cycle t+DEBOUNCE_CYCLES+3 (7 cycles with default parameters).
  - Timeout gives result_valid=1 exactly TIMEOUT_CYCLES edges after the edge that accepted arm.
- Widths: the compare is a full 8-bit unsigned equality. pass_count is 4 bits and never wraps.

Test Plan:
- Reset, arm with expected=37, switch=37, clean submit pulse -> result_valid rises 7 cycles after submit; pass=1, timeout=0, answer=37, pass_count=1; ack -> IDLE, busy=0.
- Arm with expected=37, switch=36, submit -> pass=0, answer=36, pass_count unchanged; submit bouncing 1-0-1 in 1-cycle glitches before settling -> exactly one result.
- Arm with no submit -> result_valid on the 10th edge after arm; timeout=1, pass=0, answer=0; arm pulses during RESULT are ignored.
- Submit held high before arm and kept high -> timeout result; release then press inside the next window -> normal result.
- Submit edge lands on the cycle timer==9 -> submit result, timeout=0. Then 16 consecutive passing rounds -> pass_count=15, stays at 15.
- rst=0 mid-ARMED and mid-RESULT -> next cycle: all outputs 0 and busy=0; a subsequent arm works normally.
